// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID pipeline register.
// Issues one outstanding fetch at a time, parks a word in a skid register
// when the decode stage stalls, and discards a fetch that is already in
// flight when a redirect arrives before the memory answers.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   imem_req, imem_addr         fetch request and address (addr = pc)
//   imem_ack, imem_rdata        memory response for the current address
//   stall                       hold IF/ID contents
//   redirect_valid/_target      taken branch or jump resolved downstream
//   ifid_instr/_pc4/_valid      IF/ID pipeline register
//   opcode                      ifid_instr[31:26] for the main decoder
//
// state  | meaning
// S_REQ  | fetching at pc, result goes to IF/ID
// S_WAIT | fetched word parked in skid while decode stalls, no request
// S_DROP | redirect seen mid-fetch; wait for ack, discard it, jump
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic [5:0]  opcode
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] tgt_aligned;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc4;
   logic        skid_valid;
   logic [31:0] pending_target;

   assign pc_plus4    = pc + 32'd4;
   assign tgt_aligned = {redirect_target[31:2], 2'b00};

   // Request is gated by reset directly so it is low in every reset cycle.
   assign imem_req  = !reset && (state != S_WAIT);
   assign imem_addr = pc;
   assign opcode    = ifid_instr[31:26];

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_REQ;
         pc             <= RESET_PC;
         ifid_instr     <= 32'h0000_0000;
         ifid_pc4       <= 32'h0000_0000;
         ifid_valid     <= 1'b0;
         skid_instr     <= 32'h0000_0000;
         skid_pc4       <= 32'h0000_0000;
         skid_valid     <= 1'b0;
         pending_target <= 32'h0000_0000;
      end else begin
         case (state)
            S_REQ: begin
               if (redirect_valid) begin
                  ifid_instr <= 32'h0000_0000;
                  ifid_valid <= 1'b0;
                  if (imem_ack) begin
                     pc <= tgt_aligned;
                  end else begin
                     // Fetch still in flight: the address must stay put
                     // until it is answered, so remember where to go.
                     pending_target <= tgt_aligned;
                     state          <= S_DROP;
                  end
               end else if (stall) begin
                  if (imem_ack) begin
                     skid_instr <= imem_rdata;
                     skid_pc4   <= pc_plus4;
                     skid_valid <= 1'b1;
                     pc         <= pc_plus4;
                     state      <= S_WAIT;
                  end
               end else if (imem_ack) begin
                  ifid_instr <= imem_rdata;
                  ifid_pc4   <= pc_plus4;
                  ifid_valid <= 1'b1;
                  pc         <= pc_plus4;
               end else begin
                  ifid_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  ifid_instr <= 32'h0000_0000;
                  ifid_valid <= 1'b0;
                  skid_instr <= 32'h0000_0000;
                  skid_pc4   <= 32'h0000_0000;
                  skid_valid <= 1'b0;
                  pc         <= tgt_aligned;
                  state      <= S_REQ;
               end else if (!stall) begin
                  ifid_instr <= skid_instr;
                  ifid_pc4   <= skid_pc4;
                  ifid_valid <= skid_valid;
                  skid_instr <= 32'h0000_0000;
                  skid_pc4   <= 32'h0000_0000;
                  skid_valid <= 1'b0;
                  state      <= S_REQ;
               end
            end
            S_DROP: begin
               if (redirect_valid) begin
                  ifid_instr <= 32'h0000_0000;
                  ifid_valid <= 1'b0;
                  if (imem_ack) begin
                     pc    <= tgt_aligned;
                     state <= S_REQ;
                  end else begin
                     pending_target <= tgt_aligned;
                  end
               end else if (imem_ack) begin
                  pc    <= pending_target;
                  state <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;

   logic        imem_req,   imem_req2;
   logic [31:0] imem_addr,  imem_addr2;
   logic [31:0] ifid_instr, ifid_instr2;
   logic [31:0] ifid_pc4,   ifid_pc42;
   logic        ifid_valid, ifid_valid2;
   logic [5:0]  opcode,     opcode2;

   int total = 0;
   int bad   = 0;

   fetch_unit dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
      .opcode(opcode)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .ifid_instr(ifid_instr2), .ifid_pc4(ifid_pc42), .ifid_valid(ifid_valid2),
      .opcode(opcode2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: where the fetch stream is and what decode holds.
   logic [31:0] m_pc;
   bit          m_parked;        // a fetched word waits for decode
   logic [31:0] m_park_word, m_park_pc4;
   bit          m_discard;       // in-flight fetch must be thrown away
   logic [31:0] m_jump_to;
   logic [31:0] m_instr, m_pc4;
   logic        m_valid;
   logic [31:0] last_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic ack, input logic st,
                        input logic rv, input logic [31:0] rt);
      logic [31:0] tgt;
      reset           = r;
      imem_ack        = ack;
      last_rdata      = $urandom;
      imem_rdata      = ack ? last_rdata : 32'hxxxx_xxxx;
      stall           = st;
      redirect_valid  = rv;
      redirect_target = rt;
      #1;
      chk("imem_req", {31'd0, imem_req}, {31'd0, !r && !m_parked});
      if (!r) chk("imem_addr", imem_addr, m_pc);

      tgt = rt & 32'hFFFF_FFFC;
      if (r) begin
         m_pc = 32'h0; m_parked = 0; m_discard = 0; m_jump_to = 0;
         m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (rv) begin
         // any redirect kills decode and whatever word is waiting
         m_instr = 0; m_valid = 0;
         if (m_parked) begin
            m_parked = 0; m_pc = tgt;
         end else if (ack) begin
            m_discard = 0; m_pc = tgt;
         end else begin
            m_discard = 1; m_jump_to = tgt;
         end
      end else if (m_discard) begin
         if (ack) begin m_discard = 0; m_pc = m_jump_to; end
      end else if (m_parked) begin
         if (!st) begin
            m_instr = m_park_word; m_pc4 = m_park_pc4; m_valid = 1; m_parked = 0;
         end
      end else if (st) begin
         if (ack) begin
            m_parked = 1; m_park_word = last_rdata; m_park_pc4 = m_pc + 4; m_pc = m_pc + 4;
         end
      end else if (ack) begin
         m_instr = last_rdata; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      end else begin
         m_valid = 0;
      end

      @(posedge clk);
      #1;
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc4",   ifid_pc4,   m_pc4);
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      chk("opcode",     {26'd0, opcode}, {26'd0, m_instr[31:26]});
   endtask

   logic [31:0] word8;
   bit          rr, ra, rs, rv;

   initial begin
      m_pc = 0; m_parked = 0; m_discard = 0; m_jump_to = 0;
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_park_word = 0; m_park_pc4 = 0;
      reset = 1; imem_ack = 0; imem_rdata = 0; stall = 0;
      redirect_valid = 0; redirect_target = 0;

      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("post_reset_addr", imem_addr, 32'h0);

      // Sequential fetch; the second instance checks PC wrap from FFFF_FFFC.
      cycle(0, 1, 0, 0, 0);
      chk("seq_pc4_first", ifid_pc4, 32'd4);
      chk("wrap_pc4",   ifid_pc42, 32'h0);
      chk("wrap_addr",  imem_addr2, 32'h0);
      chk("wrap_instr", ifid_instr2, last_rdata);
      chk("wrap_valid", {31'd0, ifid_valid2}, 32'd1);
      chk("wrap_op",    {26'd0, opcode2}, {26'd0, last_rdata[31:26]});
      chk("wrap_req",   {31'd0, imem_req2}, 32'd1);
      cycle(0, 1, 0, 0, 0);
      chk("seq_pc4_second", ifid_pc4, 32'd8);

      // Ack at pc=8 under a three-cycle stall.
      cycle(0, 1, 1, 0, 0);
      word8 = last_rdata;
      chk("stall_held_pc4", ifid_pc4, 32'd8);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk("release_instr", ifid_instr, word8);
      chk("release_pc4",   ifid_pc4, 32'd12);
      chk("release_addr",  imem_addr, 32'd12);

      // Redirect with ack in the same cycle; low bits dropped.
      cycle(0, 1, 0, 1, 32'h0000_0103);
      chk("redir_ack_addr", imem_addr, 32'h100);
      chk("redir_ack_valid", {31'd0, ifid_valid}, 32'd0);

      // Redirect while fetch outstanding, then a newer redirect wins.
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 32'h40);
      chk("drop_addr_hold", imem_addr, 32'h104);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 1, 1, 32'h80);
      cycle(0, 1, 0, 0, 0);
      chk("drop_latest_addr", imem_addr, 32'h80);
      cycle(0, 0, 0, 1, 32'h40);
      cycle(0, 1, 0, 1, 32'h202);
      chk("drop_same_cycle_addr", imem_addr, 32'h200);

      // Stall and redirect together while a word is parked.
      cycle(0, 1, 1, 0, 0);
      cycle(0, 0, 1, 1, 32'h300);
      chk("wait_redir_addr", imem_addr, 32'h300);
      chk("wait_redir_valid", {31'd0, ifid_valid}, 32'd0);

      // Reset while parked; an ack during reset is ignored.
      cycle(0, 1, 1, 0, 0);
      cycle(1, 1, 0, 0, 0);
      chk("reset_mid_addr", imem_addr, 32'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rr = ($urandom_range(0, 63) == 0);
         ra = !m_parked && ($urandom_range(0, 2) != 0);
         rs = ($urandom_range(0, 3) == 0);
         rv = ($urandom_range(0, 7) == 0);
         cycle(rr, ra, rs, rv, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
